// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg: state encoding and widths shared by the memory bus responders
package mem_resp_pkg;
  typedef enum logic [1:0] {RESP_IDLE, RESP_WAIT, RESP_RESP} resp_state_t;
  localparam int WAIT_CNT_W = 4;
endpackage

// File: rtl/sram_bytelane_array.sv
// sram_bytelane_array: single-port word SRAM with byte-lane writes and registered read data
module sram_bytelane_array #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  re,
  input  logic [3:0]            we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);
  logic [31:0] mem [2**ADDR_WIDTH];
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) if (we[i]) mem[addr][8*i+:8] <= wdata[8*i+:8];
    if (re) rdata <= mem[addr];
  end
endmodule

// File: rtl/data_sram_resp.sv
// data_sram_resp: data-bus responder servicing requests from on-chip SRAM with wait states
module data_sram_resp
  import mem_resp_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 10,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ready_o,
  output logic        err_o
);
  resp_state_t state, state_nxt;
  logic [WAIT_CNT_W-1:0] cnt;
  logic        we_q, bad, acc, hold;
  logic [3:0]  sel_q;
  logic [31:0] addr_q, data_q, off, rdata;
  assign off = addr_q - BASE_ADDR;
  assign bad = (|off[1:0]) || ((off >> (ADDR_WIDTH + 2)) != 32'd0);
  assign acc = rst_i && state == RESP_RESP && !bad;
  // rdata only moves on good reads; hold masks it to zero after reset or an error
  assign data_o = hold ? rdata : 32'd0;
  always_comb
    state_nxt = state == RESP_IDLE ? (ce_i ? (WAIT_CYCLES > 0 ? RESP_WAIT : RESP_RESP) : RESP_IDLE)
              : state == RESP_WAIT ? (cnt == WAIT_CNT_W'(1) ? RESP_RESP : RESP_WAIT)
              : RESP_IDLE;
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state   <= RESP_IDLE;
      cnt     <= '0;
      ready_o <= 1'b0;
      err_o   <= 1'b0;
      hold    <= 1'b0;
    end else begin
      state   <= state_nxt;
      ready_o <= state == RESP_RESP;
      err_o   <= state == RESP_RESP && bad;
      if (state == RESP_RESP) hold <= !bad && (!we_q || hold);
      if (state == RESP_WAIT) cnt <= cnt - 1'b1;
      if (state == RESP_IDLE && ce_i) begin
        cnt    <= WAIT_CNT_W'(WAIT_CYCLES);
        we_q   <= we_i;
        sel_q  <= sel_i;
        addr_q <= addr_i;
        data_q <= data_i;
      end
    end
  end
  sram_bytelane_array #(.ADDR_WIDTH(ADDR_WIDTH)) u_sram (
    .clk  (clk_i),
    .re   (acc && !we_q),
    .we   (sel_q & {4{acc && we_q}}),
    .addr (off[ADDR_WIDTH+1:2]),
    .wdata(data_q),
    .rdata(rdata)
  );
endmodule
